// File: rtl/button_conditioner.sv
// button_conditioner: synchronises raw buttons/switches, debounces each button
// and emits one-cycle press pulses with optional per-button auto-repeat.
module button_conditioner #(
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter int          REPEAT_DELAY    = 50000000,
  parameter int          REPEAT_PERIOD   = 10000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b0011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic [4:0] sw_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic [4:0] sw_sync
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;
  logic [3:0] r_btn_s1, r_btn_s2;
  logic [4:0] r_sw_s1, r_sw_s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_raw;
      r_sw_s2  <= r_sw_s1;
    end
  end
  assign sw_sync = r_sw_s2;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    state_t        r_state;
    logic          r_level, r_pulse;
    logic          w_done, w_rise, w_fall, w_fire;
    assign w_done = (r_btn_s2[i] != r_level) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign w_rise = w_done && r_btn_s2[i];
    assign w_fall = w_done && !r_btn_s2[i];
    assign w_fire = (r_state == WAIT && r_rcnt == RW'(REPEAT_DELAY)) ||
                    (r_state == REPEAT && r_rcnt == RW'(REPEAT_PERIOD));
    // a release edge wins over a coinciding repeat fire, so no pulse on release
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dcnt  <= '0;
        r_rcnt  <= '0;
        r_state <= IDLE;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_dcnt  <= (r_btn_s2[i] == r_level || w_done) ? '0 : r_dcnt + 1'b1;
        r_level <= w_done ? r_btn_s2[i] : r_level;
        r_pulse <= w_rise || (w_fire && !w_fall);
        if (w_fall || !REPEAT_MASK[i]) begin
          r_state <= IDLE;
          r_rcnt  <= '0;
        end else if (w_rise) begin
          r_state <= WAIT;
          r_rcnt  <= RW'(1);
        end else if (w_fire) begin
          r_state <= REPEAT;
          r_rcnt  <= RW'(1);
        end else if (r_state != IDLE) begin
          r_rcnt  <= r_rcnt + 1'b1;
        end
      end
    end
    assign btn_level[i] = r_level;
    assign btn_pulse[i] = r_pulse;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed scenarios plus randomized stimulus checked
// cycle by cycle against a behavioural model built from the timing rules.
module tb_button_conditioner;
  localparam int         D    = 4;
  localparam int         RD   = 20;
  localparam int         RP   = 5;
  localparam logic [3:0] MASK = 4'b0011;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = '0;
  logic [4:0] sw_raw = '0;
  logic [3:0] btn_level, btn_pulse;
  logic [4:0] sw_sync;
  int checks = 0;
  int errors = 0;
  button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .sw_sync(sw_sync)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // model: pipeline of samples, window of last D samples, press cycle per button
  logic [3:0] m_b1, m_b2, m_level, m_pulse;
  logic [4:0] m_w1, m_w2;
  bit         m_hist[4][$];
  int         m_p[4];
  int         cyc = 0;
  task automatic model_reset();
    m_b1 = '0; m_b2 = '0; m_level = '0; m_pulse = '0; m_w1 = '0; m_w2 = '0;
    for (int b = 0; b < 4; b++) m_hist[b].delete();
  endtask
  task automatic model_edge();
    bit all_diff;
    int k;
    cyc++;
    for (int b = 0; b < 4; b++) begin
      m_pulse[b] = 1'b0;
      m_hist[b].push_back(m_b2[b]);
      if (m_hist[b].size() > D) void'(m_hist[b].pop_front());
      all_diff = (m_hist[b].size() == D);
      foreach (m_hist[b][j]) if (m_hist[b][j] == m_level[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_hist[b].delete();
        m_level[b] = m_b2[b];
        if (m_b2[b]) begin
          m_pulse[b] = 1'b1;
          m_p[b] = cyc;
        end
      end else if (m_level[b] && MASK[b]) begin
        k = cyc - m_p[b];
        if (k == RD || (k > RD && (k - RD) % RP == 0)) m_pulse[b] = 1'b1;
      end
    end
    m_b2 = m_b1; m_b1 = btn_raw; m_w2 = m_w1; m_w1 = sw_raw;
  endtask
  task automatic step(input logic [3:0] b, input logic [4:0] s);
    btn_raw = b;
    sw_raw  = s;
    @(posedge clk);
    #1;
    if (!rst) model_edge();
    check("level", btn_level, m_level);
    check("pulse", btn_pulse, m_pulse);
    check("sw", sw_sync, m_w2);
  endtask
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_level", btn_level, 0);
    check("rst_pulse", btn_pulse, 0);
    check("rst_sw", sw_sync, 0);
  endtask
  initial begin
    int cnt, first, n0, n1;
    int q[$];
    int exp_rep[3] = '{6, 26, 31};
    logic [3:0] cur;
    logic [4:0] sw;
    int hold[4];
    #1;
    model_reset();
    check("init_level", btn_level, 0);
    check("init_pulse", btn_pulse, 0);
    check("init_sw", sw_sync, 0);
    step(4'b0000, 5'b0);
    step(4'b0000, 5'b0);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) step(4'b0000, 5'b0);
    // clean pause press, long hold, release
    first = 0;
    for (int n = 1; n <= 10; n++) begin
      step(4'b1000, 5'b0);
      if (btn_pulse[3] && first == 0) first = n;
    end
    check("pause_latency", first, 6);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      step(4'b1000, 5'b0);
      cnt += btn_pulse[3];
    end
    check("pause_hold_pulses", cnt, 0);
    for (int n = 0; n < 10; n++) begin
      step(4'b0000, 5'b0);
      cnt += btn_pulse[3];
    end
    check("pause_release_pulses", cnt, 0);
    check("pause_released", btn_level[3], 0);
    // auto-repeat on inc, level falls at P+27
    for (int n = 1; n <= 50; n++) begin
      step(n <= 27 ? 4'b0001 : 4'b0000, 5'b0);
      if (btn_pulse[0]) q.push_back(n);
    end
    check("rep_count", q.size(), 3);
    for (int i = 0; i < q.size() && i < 3; i++) check("rep_edge", q[i], exp_rep[i]);
    check("rep_released", btn_level[0], 0);
    // inc and dec together
    n0 = 0; n1 = 0;
    for (int n = 1; n <= 40; n++) begin
      step(4'b0011, 5'b0);
      check("sim_aligned", btn_pulse[1], btn_pulse[0]);
      n0 += btn_pulse[0];
      n1 += btn_pulse[1];
    end
    check("sim_inc_count", n0, 4);
    check("sim_dec_count", n1, 4);
    for (int n = 0; n < 10; n++) step(4'b0000, 5'b0);
    // bounce on rst button
    cnt = 0;
    for (int n = 0; n < 3; n++) begin step(4'b0100, 5'b0); cnt += btn_pulse[2]; end
    step(4'b0000, 5'b0);
    cnt += btn_pulse[2];
    for (int n = 0; n < 20; n++) begin step(4'b0100, 5'b0); cnt += btn_pulse[2]; end
    check("bounce_pulses", cnt, 1);
    for (int n = 0; n < 10; n++) step(4'b0000, 5'b0);
    // switches
    step(4'b0000, 5'b10110);
    check("sw_one_edge", sw_sync, 5'b00000);
    step(4'b0000, 5'b10110);
    check("sw_two_edges", sw_sync, 5'b10110);
    check("sw_btn_level", btn_level, 0);
    check("sw_btn_pulse", btn_pulse, 0);
    // reset mid-repeat on inc and mid-count on pause
    for (int n = 0; n < 30; n++) step(4'b0001, 5'b10110);
    for (int n = 0; n < 3; n++) step(4'b1001, 5'b10110);
    async_reset();
    step(4'b0001, 5'b0);
    step(4'b0001, 5'b0);
    rst = 1'b0;
    cnt = 0; first = 0;
    for (int n = 1; n <= 15; n++) begin
      step(4'b0001, 5'b0);
      cnt += btn_pulse[0];
      if (btn_pulse[0] && first == 0) first = n;
    end
    check("post_rst_first", first, 6);
    check("post_rst_count", cnt, 1);
    for (int n = 0; n < 10; n++) step(4'b0000, 5'b0);
    // randomized: mostly long holds, with short bursts that act as bounce
    cur = '0; sw = '0;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          cur[b] = 1'($urandom_range(0, 1));
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
        end else hold[b]--;
      end
      if ($urandom_range(0, 19) == 0) sw = 5'($urandom);
      step(cur, sw);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
